// File: rtl/alu_writeback_stage_pkg.sv
// Shared constants, opcode set and queued-entry layout for the ALU writeback stage.
// The entry's dest field is sized by DEST_W; the top casts REG_ADDR_W to and from this width.
package alu_writeback_stage_pkg;

  localparam int WORD_SIZE = 19;
  localparam int DEST_W    = 4;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_SHL = 5'd5,
    OP_SHR = 5'd6,
    OP_MUL = 5'd7,
    OP_DIV = 5'd8
  } opcode_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] result;
    logic [DEST_W-1:0]    dest;
    logic                 zero;
    logic                 neg;
    logic                 divz;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-side push bus and register-file-side pop bus of the writeback stage.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface alu_writeback_stage_if #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4
);
  import alu_writeback_stage_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [WORD_SIZE-1:0]    in_result;
  logic [4:0]              in_opcode;
  logic [REG_ADDR_W-1:0]   in_dest;
  logic                    in_div_by_zero;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORD_SIZE-1:0]    out_result;
  logic [REG_ADDR_W-1:0]   out_dest;
  logic                    out_zero;
  logic                    out_neg;
  logic                    out_divz;
  logic [$clog2(DEPTH):0]  occupancy;
`ifdef WB_BYPASS_EN
  logic                    byp_valid;
  logic [REG_ADDR_W-1:0]   byp_dest;
  logic [WORD_SIZE-1:0]    byp_result;
`endif

  modport master (
    output in_valid, in_result, in_opcode, in_dest, in_div_by_zero, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_zero, out_neg, out_divz, occupancy
`ifdef WB_BYPASS_EN
    , input byp_valid, byp_dest, byp_result
`endif
  );

  modport slave (
    input  in_valid, in_result, in_opcode, in_dest, in_div_by_zero, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_zero, out_neg, out_divz, occupancy
`ifdef WB_BYPASS_EN
    , output byp_valid, byp_dest, byp_result
`endif
  );

endinterface

// File: rtl/alu_writeback_stage_wb_fifo.sv
// Small register-based FIFO (module wb_fifo): storage, wrapping pointers, occupancy.
// Tail (newest entry) output exists only when WB_BYPASS_EN is defined.
module wb_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output entry_t                 head_o,
`ifdef WB_BYPASS_EN
  output entry_t                 tail_o,
`endif
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] slot_we;
  logic             push_ok, pop_ok;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  assign ready_o = (count_q < CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push_ok = push_i & ready_o;
  assign pop_ok  = pop_i & valid_o;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push_ok & (wr_ptr_q == PW'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = slot_we[i] ? wdata_i : mem_q[i];
    end
    // power-of-two depth: pointer increment wraps naturally
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
`ifdef WB_BYPASS_EN
  assign tail_o  = mem_q[wr_ptr_q - PW'(1)];
`endif

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: flags computed at push, entries queued in wb_fifo, valid/ready to regfile.
// Optional operand-forwarding bypass of the newest queued entry under WB_BYPASS_EN.
module alu_writeback_stage
  import alu_writeback_stage_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_writeback_stage_if.slave  bus
);

  wb_entry_t push_entry;
  wb_entry_t head_entry;
`ifdef WB_BYPASS_EN
  wb_entry_t tail_entry;
`endif

  always_comb begin
    push_entry        = '0;
    push_entry.result = bus.in_result;
    push_entry.dest   = DEST_W'(bus.in_dest);
    push_entry.zero   = (bus.in_result == '0);
    push_entry.neg    = bus.in_result[WORD_SIZE-1];
    // unknown opcodes never match DIV, so they queue with divz clear
    push_entry.divz   = bus.in_div_by_zero & (bus.in_opcode == OP_DIV);
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (bus.out_ready),
    .wdata_i (push_entry),
    .ready_o (bus.in_ready),
    .valid_o (bus.out_valid),
    .head_o  (head_entry),
`ifdef WB_BYPASS_EN
    .tail_o  (tail_entry),
`endif
    .count_o (bus.occupancy)
  );

  assign bus.out_result = head_entry.result;
  assign bus.out_dest   = REG_ADDR_W'(head_entry.dest);
  assign bus.out_zero   = head_entry.zero;
  assign bus.out_neg    = head_entry.neg;
  assign bus.out_divz   = head_entry.divz;

`ifdef WB_BYPASS_EN
  assign bus.byp_valid  = (bus.occupancy != '0);
  assign bus.byp_dest   = REG_ADDR_W'(tail_entry.dest);
  assign bus.byp_result = tail_entry.result;
`endif

endmodule
